// File: rtl/mlp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mlp_pkg
// Brief   : Shared constants, types and FSM encoding for the MLP layer engine.
// Revision: 1.0 - initial release
// ============================================================================
package mlp_pkg;

    localparam int IN_LEN  = 64;
    localparam int OUT_LEN = 64;
    localparam int X_WORDS = 16;
    localparam int W_WORDS = 1024;
    localparam int B_WORDS = 64;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [31:0] int32_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_X   = 2'd1,
        ST_LOAD_W   = 2'd2,
        ST_BIAS_OUT = 2'd3
    } state_t;

    // Signed 4-term dot product of two packed int8 words (byte k pairs with byte k).
    function automatic int32_t dot4(input logic [31:0] xw, input logic [31:0] ww);
        int32_t acc;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            acc = acc + int32_t'(int8_t'(xw[8*k +: 8])) * int32_t'(int8_t'(ww[8*k +: 8]));
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_ppu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mlp_ppu
// Brief   : Combinational requantizer: scale by unsigned Q0.SF_W, optional
//           ReLU, saturate to int8.
// Revision: 1.0 - initial release
// ============================================================================
module mlp_ppu #(
    parameter int SF_W = 12
) (
    input  logic signed [31:0] i_result,
    input  logic [SF_W-1:0]    i_scale,
    input  logic               i_relu_en,
    output logic [7:0]         o_ppu
);

    localparam int c_PROD_W = 32 + SF_W;
    localparam logic signed [c_PROD_W-1:0] c_SAT_MAX = 127;
    localparam logic signed [c_PROD_W-1:0] c_SAT_MIN = -128;

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_shift;
    logic signed [c_PROD_W-1:0] w_clip;

    // Scale is zero-extended so it always acts as a non-negative multiplier.
    assign w_prod  = c_PROD_W'(i_result) * $signed({{32{1'b0}}, i_scale});
    assign w_shift = w_prod >>> SF_W;

    always_comb begin
        w_clip = w_shift;
        if (i_relu_en && (w_shift < 0)) begin
            w_clip = '0;
        end
        if (w_clip > c_SAT_MAX) begin
            o_ppu = 8'h7F;
        end else if (w_clip < c_SAT_MIN) begin
            o_ppu = 8'h80;
        end else begin
            o_ppu = w_clip[7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mlp_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mlp_top
// Brief   : Streaming fully-connected layer engine: loads x, accumulates W.x
//           row by row, adds biases and emits int32 + requantized int8 results.
// Revision: 1.0 - initial release
// ============================================================================
module mlp_top #(
    parameter int IN_LEN  = 64,
    parameter int OUT_LEN = 64,
    parameter int SF_W    = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SF_W-1:0] scaling_factor,
    input  logic            ready,
    input  logic [31:0]     data_in,
    output logic            valid,
    output logic [31:0]     ofmap,
    output logic            done,
    output logic [7:0]      ppu_out
);

    import mlp_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [9:0]        r_cnt;
    logic              w_last;
    logic              r_mode;
    logic [SF_W-1:0]   r_sf;
    logic [IN_LEN*8-1:0] r_x_buf;
    int32_t            r_psum [OUT_LEN];

    logic [5:0]        w_row;
    logic [3:0]        w_grp;
    int32_t            w_dot;
    int32_t            w_result;
    logic [7:0]        w_ppu;

    assign w_row = r_cnt[9:4];
    assign w_grp = r_cnt[3:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ready) begin
                    w_state_next = ST_LOAD_X;
                end
            end
            ST_LOAD_X: begin
                w_last = (r_cnt == 10'(X_WORDS - 1));
                if (w_last) begin
                    w_state_next = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                w_last = (r_cnt == 10'(W_WORDS - 1));
                if (w_last) begin
                    w_state_next = ST_BIAS_OUT;
                end
            end
            ST_BIAS_OUT: begin
                w_last = (r_cnt == 10'(B_WORDS - 1));
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Word counter restarts at every phase boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_sf   <= '0;
        end else begin
            if (r_state == ST_IDLE || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 10'd1;
            end
            if (r_state == ST_IDLE && ready) begin
                r_mode <= mode;
                r_sf   <= scaling_factor;
            end
        end
    end

    assign w_dot = dot4(r_x_buf[32*w_grp +: 32], data_in);

    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD_X) begin
            r_x_buf[32*w_grp +: 32] <= data_in;
        end
        if (r_state == ST_LOAD_W) begin
            r_psum[w_row] <= ((w_grp == 4'd0) ? int32_t'(0) : r_psum[w_row]) + w_dot;
        end
    end

    assign w_result = r_psum[r_cnt[5:0]] + int32_t'(data_in);

    mlp_ppu #(
        .SF_W (SF_W)
    ) u_ppu (
        .i_result  (w_result),
        .i_scale   (r_sf),
        .i_relu_en (~r_mode),
        .o_ppu     (w_ppu)
    );

    // ofmap/ppu_out keep their last value outside BIAS_OUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            done    <= 1'b0;
            ofmap   <= '0;
            ppu_out <= '0;
        end else if (r_state == ST_BIAS_OUT) begin
            valid   <= 1'b1;
            done    <= w_last;
            ofmap   <= w_result;
            ppu_out <= w_ppu;
        end else begin
            valid   <= 1'b0;
            done    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mlp_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mlp_top
// Brief   : Directed self-checking bench for the MLP layer engine.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mlp_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        ready = 1'b0;
    logic [11:0] sf = 12'd0;
    logic [31:0] data_in = 32'd0;
    logic        valid;
    logic        done;
    logic [31:0] ofmap;
    logic [7:0]  ppu_out;

    mlp_top #(
        .IN_LEN  (64),
        .OUT_LEN (64),
        .SF_W    (12)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .scaling_factor (sf),
        .ready          (ready),
        .data_in        (data_in),
        .valid          (valid),
        .ofmap          (ofmap),
        .done           (done),
        .ppu_out        (ppu_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int x [64];
    int w [64][64];
    int b [64];
    int exp_of [64];
    int exp_pp [64];

    logic [31:0] obs_of [64];
    logic [7:0]  obs_pp [64];
    int mon_cnt, mon_done, mon_done_idx, first_cyc, last_cyc, start_cyc;
    int cyc = 0;

    // Record every valid result and done pulse, sampled 1 ns after the edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (valid === 1'b1) begin
            if (mon_cnt < 64) begin
                obs_of[mon_cnt] = ofmap;
                obs_pp[mon_cnt] = ppu_out;
            end
            if (mon_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            mon_cnt++;
        end
        if (done === 1'b1) begin
            mon_done++;
            mon_done_idx = mon_cnt;
        end
    end

    function automatic logic [31:0] word_at(input int i);
        int n, r, g;
        if (i < 16)
            return {8'(x[4*i+3]), 8'(x[4*i+2]), 8'(x[4*i+1]), 8'(x[4*i])};
        if (i < 1040) begin
            n = i - 16;
            r = n / 16;
            g = n % 16;
            return {8'(w[r][4*g+3]), 8'(w[r][4*g+2]), 8'(w[r][4*g+1]), 8'(w[r][4*g])};
        end
        return 32'(b[i-1040]);
    endfunction

    function automatic void model(input logic m, input logic [11:0] s);
        int     acc;
        longint p;
        for (int o = 0; o < 64; o++) begin
            acc = b[o];
            for (int i = 0; i < 64; i++) acc += x[i] * w[o][i];
            exp_of[o] = acc;
            p = (longint'(acc) * longint'({20'd0, s})) >>> 12;
            if (!m && p < 0) p = 0;
            if (p > 127) p = 127;
            if (p < -128) p = -128;
            exp_pp[o] = int'(p);
        end
    endfunction

    task automatic fill(input int xv, input int wv, input int bv);
        for (int i = 0; i < 64; i++) begin
            x[i] = xv;
            b[i] = bv;
            for (int j = 0; j < 64; j++) w[i][j] = wv;
        end
    endtask

    // Start a pass and stream nwords words; control pins are scrambled after
    // the start so that only the latched copies can affect the result.
    task automatic run_pass(input logic m, input logic [11:0] s, input int glitch_at,
                            input int nwords, input int tail);
        mon_cnt = 0; mon_done = 0; mon_done_idx = -1; first_cyc = -1; last_cyc = -1;
        @(negedge clk);
        ready = 1'b1; mode = m; sf = s;
        start_cyc = cyc + 1;
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            ready   = (i == glitch_at);
            mode    = ~m;
            sf      = 12'd0;
            data_in = word_at(i);
        end
        if (tail > 0) begin
            @(negedge clk);
            ready = 1'b0; data_in = 32'd0;
            repeat (tail - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (ofmap !== 32'd0) begin n_fail++; $display("FAIL reset_ofmap got %h want 0", ofmap); end
        n_checks++; if (ppu_out !== 8'd0) begin n_fail++; $display("FAIL reset_ppu got %h want 0", ppu_out); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_ones;
        fill(1, 1, 0);
        run_pass(1'b0, 12'd4095, -1, 1104, 3);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'd64) begin n_fail++; $display("FAIL ones_ofmap[%0d] got %0d want 64", o, $signed(obs_of[o])); end
            n_checks++; if (obs_pp[o] !== 8'd63) begin n_fail++; $display("FAIL ones_ppu[%0d] got %0d want 63", o, $signed(obs_pp[o])); end
        end
        n_checks++; if (mon_cnt !== 64) begin n_fail++; $display("FAIL ones_valid_count got %0d want 64", mon_cnt); end
        n_checks++; if (mon_done !== 1 || mon_done_idx !== 64) begin n_fail++; $display("FAIL ones_done got count %0d at %0d want 1 at 64", mon_done, mon_done_idx); end
        n_checks++; if (first_cyc - start_cyc !== 1041) begin n_fail++; $display("FAIL ones_latency got %0d want 1041", first_cyc - start_cyc); end
        n_checks++; if (last_cyc - first_cyc !== 63) begin n_fail++; $display("FAIL ones_valid_span got %0d want 63", last_cyc - first_cyc); end
        n_checks++; if (valid !== 1'b0 || ofmap !== 32'd64 || ppu_out !== 8'd63) begin n_fail++; $display("FAIL ones_hold got v=%b of=%0d pp=%0d want v=0 of=64 pp=63", valid, ofmap, ppu_out); end
    endtask

    task automatic test_saturate;
        fill(-128, -128, 5);
        run_pass(1'b0, 12'd4095, -1, 1104, 3);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'd1048581) begin n_fail++; $display("FAIL sat_ofmap[%0d] got %0d want 1048581", o, $signed(obs_of[o])); end
            n_checks++; if (obs_pp[o] !== 8'h7F) begin n_fail++; $display("FAIL sat_ppu[%0d] got %0d want 127", o, $signed(obs_pp[o])); end
        end
    endtask

    task automatic test_negative;
        fill(1, -1, 0);
        run_pass(1'b0, 12'd4095, -1, 1104, 3);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'hFFFF_FFC0) begin n_fail++; $display("FAIL neg_relu_ofmap[%0d] got %0d want -64", o, $signed(obs_of[o])); end
            n_checks++; if (obs_pp[o] !== 8'h00) begin n_fail++; $display("FAIL neg_relu_ppu[%0d] got %0d want 0", o, $signed(obs_pp[o])); end
        end
        run_pass(1'b1, 12'd4095, -1, 1104, 3);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'hFFFF_FFC0) begin n_fail++; $display("FAIL neg_part_ofmap[%0d] got %0d want -64", o, $signed(obs_of[o])); end
            n_checks++; if (obs_pp[o] !== 8'hC0) begin n_fail++; $display("FAIL neg_part_ppu[%0d] got %0d want -64", o, $signed(obs_pp[o])); end
        end
    endtask

    task automatic test_wrap;
        fill(0, 1, 32'h7FFF_FFFF);
        x[0] = 1;
        run_pass(1'b1, 12'd4095, -1, 1104, 3);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_ofmap[%0d] got %h want 80000000", o, obs_of[o]); end
            n_checks++; if (obs_pp[o] !== 8'h80) begin n_fail++; $display("FAIL wrap_ppu[%0d] got %0d want -128", o, $signed(obs_pp[o])); end
        end
    endtask

    task automatic test_ready_ignored;
        fill(1, 1, 0);
        run_pass(1'b0, 12'd4095, 600, 1104, 3);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'd64) begin n_fail++; $display("FAIL rdy_ofmap[%0d] got %0d want 64", o, $signed(obs_of[o])); end
            n_checks++; if (obs_pp[o] !== 8'd63) begin n_fail++; $display("FAIL rdy_ppu[%0d] got %0d want 63", o, $signed(obs_pp[o])); end
        end
        n_checks++; if (mon_cnt !== 64) begin n_fail++; $display("FAIL rdy_valid_count got %0d want 64", mon_cnt); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 64; i++) begin
            x[i] = int'($urandom_range(255)) - 128;
            b[i] = int'($urandom);
            for (int j = 0; j < 64; j++) w[i][j] = int'($urandom_range(255)) - 128;
        end
        model(1'b1, 12'd3001);
        run_pass(1'b1, 12'd3001, -1, 1104, 1);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'(exp_of[o])) begin n_fail++; $display("FAIL b2b1_ofmap[%0d] got %h want %h", o, obs_of[o], 32'(exp_of[o])); end
            n_checks++; if (obs_pp[o] !== 8'(exp_pp[o])) begin n_fail++; $display("FAIL b2b1_ppu[%0d] got %h want %h", o, obs_pp[o], 8'(exp_pp[o])); end
        end
        n_checks++; if (mon_cnt !== 64 || mon_done !== 1) begin n_fail++; $display("FAIL b2b1_counts got valid=%0d done=%0d want 64/1", mon_cnt, mon_done); end
        for (int i = 0; i < 64; i++) begin
            b[i] = exp_of[i];
            x[i] = int'($urandom_range(255)) - 128;
            for (int j = 0; j < 64; j++) w[i][j] = int'($urandom_range(255)) - 128;
        end
        model(1'b0, 12'd517);
        run_pass(1'b0, 12'd517, -1, 1104, 3);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'(exp_of[o])) begin n_fail++; $display("FAIL b2b2_ofmap[%0d] got %h want %h", o, obs_of[o], 32'(exp_of[o])); end
            n_checks++; if (obs_pp[o] !== 8'(exp_pp[o])) begin n_fail++; $display("FAIL b2b2_ppu[%0d] got %h want %h", o, obs_pp[o], 8'(exp_pp[o])); end
        end
        n_checks++; if (mon_cnt !== 64 || mon_done !== 1) begin n_fail++; $display("FAIL b2b2_counts got valid=%0d done=%0d want 64/1", mon_cnt, mon_done); end
    endtask

    task automatic test_reset_mid;
        fill(1, 1, 0);
        run_pass(1'b0, 12'd4095, -1, 1050, 0);
        @(posedge clk);
        #2;
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got %b want 1", valid); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got v=%b d=%b want 0/0", valid, done); end
        n_checks++; if (ofmap !== 32'd0 || ppu_out !== 8'd0) begin n_fail++; $display("FAIL midrst_data got of=%h pp=%h want 0/0", ofmap, ppu_out); end
        @(negedge clk);
        ready = 1'b0; data_in = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        fill(2, 3, 7);
        run_pass(1'b0, 12'd4095, -1, 1104, 3);
        for (int o = 0; o < 64; o++) begin
            n_checks++; if (obs_of[o] !== 32'd391) begin n_fail++; $display("FAIL midrst_ofmap[%0d] got %0d want 391", o, $signed(obs_of[o])); end
            n_checks++; if (obs_pp[o] !== 8'd127) begin n_fail++; $display("FAIL midrst_ppu[%0d] got %0d want 127", o, $signed(obs_pp[o])); end
        end
        n_checks++; if (mon_cnt !== 64 || mon_done !== 1) begin n_fail++; $display("FAIL midrst_counts got valid=%0d done=%0d want 64/1", mon_cnt, mon_done); end
    endtask

    initial begin
        test_reset;
        test_all_ones;
        test_saturate;
        test_negative;
        test_wrap;
        test_ready_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
